zp_sub_array: RTL

Parametrised, multi-lane zero-point subtraction stage for the quantised datapath. Each of `LANES` signed lanes has its own zero-point register loaded through a lane-addressed write port. The block computes `data - zp` per lane and optionally saturates the result. Vectors move through a valid/ready handshake with a 2-entry skid buffer, so it sits between the systolic array drain and the requantiser without combinational ready paths.

---
 rtl/tpu_quant_pkg.sv | 40 ++++
 rtl/zp_skid_buf.sv | 93 +++++++++
 rtl/zp_sub_array.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tpu_quant_pkg.sv
// -----------------------------------------------------------------------------
// tpu_quant_pkg
// Shared definitions for the quantised datapath.
//   ACC_W      : default accumulator / input data width.
//   ZP_W       : default zero-point width.
//   SAT_W      : width of the working value accepted by sat_signed.
//   sat_signed : width-generic signed clamp. The caller sign-extends its value
//                to SAT_W bits and names the target width (1..SAT_W-1).
//                Returns {saturated_flag, clamped_value[SAT_W-1:0]}; the low
//                out_w bits of the clamped value are the narrowed result.
// -----------------------------------------------------------------------------
package tpu_quant_pkg;

  localparam int ACC_W = 32;
  localparam int ZP_W  = 32;
  localparam int SAT_W = 64;

  function automatic logic [SAT_W:0] sat_signed(
    input logic signed [SAT_W-1:0] val,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] one_v;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    logic        [SAT_W:0]   res_v;
    one_v = {{(SAT_W-1){1'b0}}, 1'b1};
    max_v = (one_v <<< (out_w - 1)) - one_v;
    // In two's complement, -max-1 is simply the bitwise complement of max.
    min_v = ~max_v;
    if (val > max_v) begin
      res_v = {1'b1, max_v};
    end else if (val < min_v) begin
      res_v = {1'b1, min_v};
    end else begin
      res_v = {1'b0, val};
    end
    return res_v;
  endfunction

endpackage

// File: rtl/zp_skid_buf.sv
// -----------------------------------------------------------------------------
// zp_skid_buf
// Generic 2-entry valid/ready skid buffer: an output register plus one skid
// register. in_ready_o is a pure register (high iff fewer than two entries are
// held after the current cycle), so no combinational path runs from
// out_ready_i to in_ready_o. Order is preserved; nothing is dropped or
// duplicated. in_ready_o resets low and rises on the first clock after reset.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake
//   in_data_i  [W]         upstream payload
//   out_valid_o/out_ready_i downstream handshake
//   out_data_o [W]         downstream payload (registered)
// -----------------------------------------------------------------------------
module zp_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_r;
  logic [W-1:0] out_data_r;
  logic         skid_valid_r;
  logic [W-1:0] skid_data_r;
  logic         ready_r;

  logic         push_s;
  logic         pop_s;
  logic         out_valid_n_s;
  logic [W-1:0] out_data_n_s;
  logic         skid_valid_n_s;
  logic [W-1:0] skid_data_n_s;

  assign push_s = in_valid_i && ready_r;
  assign pop_s  = out_valid_r && out_ready_i;

  // Next-state of both slots; the output slot is refilled from skid first.
  always_comb begin
    out_valid_n_s  = out_valid_r;
    out_data_n_s   = out_data_r;
    skid_valid_n_s = skid_valid_r;
    skid_data_n_s  = skid_data_r;
    if (!out_valid_r || pop_s) begin
      if (skid_valid_r) begin
        // Buffer was full, so no push can coincide with this promotion.
        out_valid_n_s  = 1'b1;
        out_data_n_s   = skid_data_r;
        skid_valid_n_s = 1'b0;
      end else if (push_s) begin
        out_valid_n_s  = 1'b1;
        out_data_n_s   = in_data_i;
      end else begin
        out_valid_n_s  = 1'b0;
      end
    end else begin
      if (push_s) begin
        skid_valid_n_s = 1'b1;
        skid_data_n_s  = in_data_i;
      end else begin
        skid_valid_n_s = skid_valid_r;
      end
    end
  end

  // Slot registers and the registered ready flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
      ready_r      <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_n_s;
      out_data_r   <= out_data_n_s;
      skid_valid_r <= skid_valid_n_s;
      skid_data_r  <= skid_data_n_s;
      ready_r      <= !(out_valid_n_s && skid_valid_n_s);
    end
  end

  assign in_ready_o  = ready_r;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;

endmodule

// File: rtl/zp_sub_array.sv
// -----------------------------------------------------------------------------
// zp_sub_array
// Multi-lane zero-point subtraction: out[k] = in[k] - zp[k], each lane with its
// own zero-point register loaded through a lane-addressed write port. Results
// pass through a 2-entry skid buffer so in_ready_o has no combinational path
// from in_valid_i or out_ready_i.
// Build option: define ZP_SUB_SAT_EN to clamp out-of-range results to the
// OUT_W signed range and flag them in out_sat_o; otherwise results wrap to the
// low OUT_W bits and out_sat_o is constant zero.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   zp_we_i, zp_lane_i, zp_i zero-point write (lanes >= LANES ignored)
//   zp_clr_i                 clear all loaded flags (values retained)
//   zp_ready_o               registered "all lanes loaded"
//   in_valid_i/in_ready_o    input handshake, in_data_i lane k at [k*IN_W +: IN_W]
//   out_valid_o/out_ready_i  output handshake
//   out_data_o               results, lane k at [k*OUT_W +: OUT_W]
//   out_sat_o                per-lane saturation flags aligned with out_data_o
// -----------------------------------------------------------------------------
module zp_sub_array #(
  parameter  int LANES  = 8,
  parameter  int IN_W   = tpu_quant_pkg::ACC_W,
  parameter  int ZP_W   = tpu_quant_pkg::ZP_W,
  parameter  int OUT_W  = 32,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   zp_we_i,
  input  logic [LANE_W-1:0]      zp_lane_i,
  input  logic [ZP_W-1:0]        zp_i,
  input  logic                   zp_clr_i,
  output logic                   zp_ready_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*IN_W-1:0]  in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*OUT_W-1:0] out_data_o,
  output logic [LANES-1:0]       out_sat_o
);

  import tpu_quant_pkg::*;

  localparam int PAY_W = LANES * (OUT_W + 1);

  logic [ZP_W-1:0]        zp_q_r [LANES];
  logic [LANES-1:0]       loaded_r;
  logic                   zp_ready_r;

  logic [LANES-1:0]       we_onehot_s;
  logic [LANES-1:0]       eff_loaded_s;
  logic                   all_loaded_s;
  logic [LANES*OUT_W-1:0] res_data_s;
  logic [LANES-1:0]       res_sat_s;
  logic                   skid_in_valid_s;
  logic                   skid_ready_s;
  logic [PAY_W-1:0]       skid_out_s;

  // Lane decode; an address with no matching lane produces no strobe.
  always_comb begin
    we_onehot_s = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (zp_we_i && (zp_lane_i == LANE_W'(k))) begin
        we_onehot_s[k] = 1'b1;
      end else begin
        we_onehot_s[k] = 1'b0;
      end
    end
  end

  // Loaded mask as it will stand after this cycle: clear first, then write.
  always_comb begin
    if (zp_clr_i) begin
      eff_loaded_s = we_onehot_s;
    end else begin
      eff_loaded_s = loaded_r | we_onehot_s;
    end
  end

  assign all_loaded_s = &eff_loaded_s;

  // Zero-point file, loaded mask and the registered all-loaded status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < LANES; k++) begin
        zp_q_r[k] <= {ZP_W{1'b0}};
      end
      loaded_r   <= {LANES{1'b0}};
      zp_ready_r <= 1'b0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (we_onehot_s[k]) begin
          zp_q_r[k] <= zp_i;
        end else begin
          zp_q_r[k] <= zp_q_r[k];
        end
      end
      loaded_r   <= eff_loaded_s;
      zp_ready_r <= all_loaded_s;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [ZP_W-1:0]   zp_eff_s;
    logic signed [IN_W:0] diff_s;

    // A write in the same cycle as an acceptance is used by that vector.
    always_comb begin
      if (we_onehot_s[k]) begin
        zp_eff_s = zp_i;
      end else begin
        zp_eff_s = zp_q_r[k];
      end
    end

    // One extra bit of headroom keeps the difference exact.
    assign diff_s = (IN_W+1)'($signed(in_data_i[k*IN_W +: IN_W]))
                  - (IN_W+1)'($signed(zp_eff_s));

`ifdef ZP_SUB_SAT_EN
    logic [SAT_W:0] sat_res_s;
    logic           unused_sat_s;
    assign sat_res_s                     = sat_signed(SAT_W'(diff_s), OUT_W);
    assign res_data_s[k*OUT_W +: OUT_W]  = sat_res_s[OUT_W-1:0];
    assign res_sat_s[k]                  = sat_res_s[SAT_W];
    assign unused_sat_s                  = ^sat_res_s;
`else
    logic unused_diff_s;
    assign res_data_s[k*OUT_W +: OUT_W]  = diff_s[OUT_W-1:0];
    assign res_sat_s[k]                  = 1'b0;
    assign unused_diff_s                 = ^diff_s;
`endif
  end

  // Inputs stall until every lane holds a valid zero-point.
  assign skid_in_valid_s = in_valid_i && all_loaded_s;
  assign in_ready_o      = skid_ready_s && all_loaded_s;

  zp_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (skid_in_valid_s),
    .in_ready_o  (skid_ready_s),
    .in_data_i   ({res_sat_s, res_data_s}),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (skid_out_s)
  );

  assign out_data_o = skid_out_s[LANES*OUT_W-1:0];
  assign out_sat_o  = skid_out_s[PAY_W-1 -: LANES];
  assign zp_ready_o = zp_ready_r;

endmodule
